ysyx_22050133_csr_unit: RTL
===========================

YSYX_22050133_CSR_UNIT -- requirements
Module: ysyx_22050133_csr_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath and CSR width (32 or 64).
REQ-002 SHALL have parameter MTVEC_RST, default 0, meaning reset value of mtvec.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit, meaning a request is offered.
REQ-006 SHALL have port req_ready, output, 1 bit, meaning the unit accepts a request this cycle.
REQ-007 SHALL have port req_kind, input, 2 bits, meaning 0 CSR op, 1 ECALL, 2 MRET, 3 reserved (treated as illegal).
REQ-008 SHALL have port req_funct3, input, 3 bits, meaning CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-009 SHALL have port req_addr, input, 12 bits, meaning CSR address.
REQ-010 SHALL have port req_src, input, 5 bits, meaning rs1 index, or zimm for immediate ops.
REQ-011 SHALL have port req_wdata, input, XLEN bits, meaning rs1 value.
REQ-012 SHALL have port req_pc, input, XLEN bits, meaning PC of the requesting instruction.
REQ-013 SHALL have ports resp_valid (1), resp_rdata (XLEN) and resp_illegal (1), all outputs, meaning registered response.
REQ-014 SHALL have ports redirect_valid (1) and redirect_pc (XLEN), both outputs, meaning fetch redirect.
REQ-015 SHALL have port instret_inc, input, 1 bit, meaning one instruction retired this cycle.

Function
REQ-016 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342 and mip 0x344 (read-only zero); any other address is illegal.
REQ-017 SHALL use FSM states IDLE, TRAP, RET; req_ready is 1 only in IDLE.
REQ-018 SHALL, for an accepted CSR op, return the old CSR value on resp_rdata with resp_valid=1 exactly one cycle after acceptance.
REQ-019 SHALL compute the new value as src for RW, old|src for RS, and old&~src for RC, where src is req_wdata for register ops or the zero-extended req_src for immediate ops.
REQ-020 SHALL suppress the write for RS, RC, RSI and RCI when req_src==0, while still returning the read value.
REQ-021 SHALL, for an illegal address or kind 3, write nothing and respond with resp_illegal=1 and resp_rdata=0 one cycle later.
REQ-022 SHALL, on ECALL acceptance, go to TRAP, set mepc=req_pc, mcause=11, MPIE=MIE, MIE=0, MPP=2'b11, and in the TRAP cycle assert redirect_valid with redirect_pc=mtvec&~3 before returning to IDLE.
REQ-023 SHALL, on MRET acceptance, go to RET, set MIE=MPIE, MPIE=1, MPP=0, and in the RET cycle assert redirect_valid with redirect_pc=mepc before returning to IDLE.
REQ-024 SHALL make resp_valid and redirect_valid single-cycle pulses, with resp_valid=0 on ECALL and MRET.
REQ-025 SHALL force mepc[1:0]=0 and mtvec[1]=0 on every write.
REQ-026 SHALL ignore req_valid outside IDLE; the requester holds the request until accepted.

Reset
REQ-027 SHALL, on rst, immediately (asynchronously) force state=IDLE, resp_valid=0, resp_illegal=0, resp_rdata=0, redirect_valid=0 and redirect_pc=0.
REQ-028 SHALL reset mstatus to 64'ha00001800 when XLEN=64 and to 32'h1800 when XLEN=32, mtvec to MTVEC_RST, and all other CSRs to 0.
REQ-029 SHALL abandon a TRAP or RET in progress on reset, with no redirect issued.

Configuration
REQ-030 SHALL, with YSYX_22050133_CSR_COUNTER_EN defined, implement 64-bit mcycle 0xB00 (increments every cycle) and minstret 0xB02 (increments when instret_inc=1), readable and writable; for XLEN=32, the high halves are also at 0xB80 and 0xB82.
REQ-031 SHALL give a CSR-op write to a counter priority over that counter's increment in the same cycle.
REQ-032 SHALL, without YSYX_22050133_CSR_COUNTER_EN, have no counter storage and treat the counter addresses as illegal.

Structure
REQ-033 SHALL take the CSR address constants, req_kind codes, funct3 codes and FSM state encoding from shared package ysyx_22050133_csr_pkg.
REQ-034 SHALL place the counters in one sub-module ysyx_22050133_csr_counter; there are no other sub-modules.

Verification
REQ-035 SHALL cover: after reset, CSRRS addr 0x300, src 0 -> resp_rdata=0xa00001800, resp_illegal=0, mstatus unchanged.
REQ-036 SHALL cover: CSRRW 0x305 with wdata 0x80000102 -> next read returns 0x80000100.
REQ-037 SHALL cover: mtvec=0x80000100, MIE=1, ECALL pc=0x80000040 -> redirect pulse to 0x80000100 one cycle later, mepc=0x80000040, mcause=11, MIE=0, MPIE=1, req_ready low for that cycle.
REQ-038 SHALL cover: MRET after that ECALL -> redirect to 0x80000040, MIE=1.
REQ-039 SHALL cover: CSRRC 0x7C0 -> resp_illegal=1, resp_rdata=0; CSRRSI 0x340 with zimm 0 -> no write.
REQ-040 SHALL cover: with counters enabled, CSRRW mcycle=5 while instret_inc=1 -> mcycle reads 5+n after n cycles, and rst asserted in TRAP -> no redirect pulse.

Source files
------------

// File: rtl/ysyx_22050133_csr_pkg.sv
// ysyx_22050133_csr_pkg: CSR addresses, request codes and FSM states shared by the CSR unit and its bench.
package ysyx_22050133_csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [1:0] KIND_CSR   = 2'd0;
  localparam logic [1:0] KIND_ECALL = 2'd1;
  localparam logic [1:0] KIND_MRET  = 2'd2;
  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP    = 11;
  localparam int MCAUSE_ECALL_M = 11;
  typedef enum logic [1:0] {IDLE = 2'd0, TRAP = 2'd1, RET = 2'd2} csr_state_e;
  function automatic logic [63:0] mstatus_rst(input int xlen);
    return xlen == 64 ? 64'ha_0000_1800 : 64'h1800;
  endfunction
endpackage

// File: rtl/ysyx_22050133_csr_counter.sv
// ysyx_22050133_csr_counter: 64-bit mcycle/minstret where a CSR write wins over the increment.
// Present only when YSYX_22050133_CSR_COUNTER_EN is defined.
`ifdef YSYX_22050133_CSR_COUNTER_EN
module ysyx_22050133_csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic            sel_i,
  input  logic            hi_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            instret_inc_i,
  output logic [63:0]     mcycle_o,
  output logic [63:0]     minstret_o
);
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  // On RV32 a write only replaces the addressed half.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [XLEN-1:0] wd, input logic hi);
    return XLEN == 64 ? 64'(wd) : hi ? {wd[31:0], old[31:0]} : {old[63:32], wd[31:0]};
  endfunction
  always_comb begin
    mcycle_d = we_i && !sel_i ? merge(mcycle_q, wdata_i, hi_i) : mcycle_q + 64'd1;
    minstret_d = we_i && sel_i ? merge(minstret_q, wdata_i, hi_i) : minstret_q + 64'(instret_inc_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_q <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
  assign mcycle_o = mcycle_q;
  assign minstret_o = minstret_q;
endmodule
`endif

// File: rtl/ysyx_22050133_csr_unit.sv
// ysyx_22050133_csr_unit: machine-mode CSR file with ECALL/MRET trap sequencing and fetch redirect.
// Define YSYX_22050133_CSR_COUNTER_EN to add the mcycle/minstret counters.
module ysyx_22050133_csr_unit
  import ysyx_22050133_csr_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [4:0]      req_src,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [XLEN-1:0] req_pc,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            instret_inc
);
  localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(mstatus_rst(XLEN));
  csr_state_e state_q, state_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic resp_valid_q, resp_valid_d, resp_illegal_q, resp_illegal_d;
  logic accept, is_csr, is_ecall, is_mret, op_rw, op_rs, op_rc, addr_ok, csr_ok, wr_en, cnt_we;
  logic [XLEN-1:0] src, old_val, new_val;
  logic [63:0] mcycle, minstret;
`ifdef YSYX_22050133_CSR_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
  ysyx_22050133_csr_counter #(.XLEN(XLEN)) u_counter (
    .clk(clk),
    .rst(rst),
    .we_i(cnt_we),
    .sel_i(req_addr[1]),
    .hi_i(req_addr[7]),
    .wdata_i(new_val),
    .instret_inc_i(instret_inc),
    .mcycle_o(mcycle),
    .minstret_o(minstret)
  );
`else
  localparam bit CNT_EN = 1'b0;
  logic unused_cnt;
  assign mcycle = '0;
  assign minstret = '0;
  assign unused_cnt = ^{instret_inc, cnt_we};
`endif
  assign req_ready = state_q == IDLE;
  assign accept = req_valid && req_ready;
  assign is_csr = req_kind == KIND_CSR;
  assign is_ecall = req_kind == KIND_ECALL;
  assign is_mret = req_kind == KIND_MRET;
  assign op_rw = req_funct3 == F3_RW || req_funct3 == F3_RWI;
  assign op_rs = req_funct3 == F3_RS || req_funct3 == F3_RSI;
  assign op_rc = req_funct3 == F3_RC || req_funct3 == F3_RCI;
  assign src = req_funct3[2] ? XLEN'(req_src) : req_wdata;
  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (req_addr)
      CSR_MSTATUS:   old_val = mstatus_q;
      CSR_MIE:       old_val = mie_q;
      CSR_MTVEC:     old_val = mtvec_q;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MIP:       old_val = '0;
      CSR_MCYCLE:    begin old_val = mcycle[XLEN-1:0]; addr_ok = CNT_EN; end
      CSR_MINSTRET:  begin old_val = minstret[XLEN-1:0]; addr_ok = CNT_EN; end
      CSR_MCYCLEH:   begin old_val = XLEN'(mcycle[63:32]); addr_ok = CNT_EN && XLEN == 32; end
      CSR_MINSTRETH: begin old_val = XLEN'(minstret[63:32]); addr_ok = CNT_EN && XLEN == 32; end
      default:       addr_ok = 1'b0;
    endcase
  end
  assign csr_ok = is_csr && addr_ok && (op_rw || op_rs || op_rc);
  assign new_val = op_rw ? src : op_rs ? old_val | src : old_val & ~src;
  // Set/clear with x0 or zimm 0 is a pure read.
  assign wr_en = accept && csr_ok && (op_rw || req_src != 5'd0);
  assign cnt_we = wr_en && req_addr inside {CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH};
  always_comb begin
    state_d = state_q != IDLE ? IDLE : accept && is_ecall ? TRAP : accept && is_mret ? RET : IDLE;
    mstatus_d = mstatus_q;
    mie_d = mie_q;
    mtvec_d = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    resp_valid_d = accept && !is_ecall && !is_mret;
    resp_illegal_d = resp_valid_d && !csr_ok;
    resp_rdata_d = resp_valid_d && csr_ok ? old_val : '0;
    if (wr_en) begin
      case (req_addr)
        CSR_MSTATUS:  mstatus_d = new_val;
        CSR_MIE:      mie_d = new_val;
        CSR_MTVEC:    mtvec_d = new_val & ~XLEN'(2);
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d = new_val & ~XLEN'(3);
        CSR_MCAUSE:   mcause_d = new_val;
        default:      ;
      endcase
    end
    if (accept && is_ecall) begin
      mepc_d = req_pc & ~XLEN'(3);
      mcause_d = XLEN'(MCAUSE_ECALL_M);
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE] = 1'b0;
      mstatus_d[MSTATUS_MPP+:2] = 2'b11;
    end
    if (accept && is_mret) begin
      mstatus_d[MSTATUS_MIE] = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
      mstatus_d[MSTATUS_MPP+:2] = 2'b00;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mstatus_q <= MSTATUS_RST;
      mie_q <= '0;
      mtvec_q <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      resp_valid_q <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      mstatus_q <= mstatus_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      resp_valid_q <= resp_valid_d;
      resp_illegal_q <= resp_illegal_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_illegal = resp_illegal_q;
  assign resp_rdata = resp_rdata_q;
  assign redirect_valid = state_q != IDLE;
  assign redirect_pc = state_q == TRAP ? {mtvec_q[XLEN-1:2], 2'b00} : state_q == RET ? mepc_q : '0;
endmodule
